// File: rtl/wb_master_if.sv
// Core-side request/response and Wishbone classic bus signals of the wb_master bridge.
// The master modport is the bridge's view. The slave modport is the view of the core and Wishbone slave around it.
interface wb_master_if;
  // Handshakes: a request transfers on a rising edge where req_valid_i && req_ready_o.
  // A response transfers on a rising edge where rsp_valid_o && rsp_ready_i.
  // Once valid is raised, it and its payload are held until that transfer edge.
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_sel_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_sel_i,
    input  rsp_ready_i, wbm_dat_i, wbm_ack_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_sel_i,
    output rsp_ready_i, wbm_dat_i, wbm_ack_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_master.sv
// Single-outstanding bridge from a valid/ready core port to a Wishbone classic master.
// A strobe that gets no ack within TIMEOUT cycles ends with an error response.
module wb_master #(
  parameter int TIMEOUT = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  wb_master_if.master       bus,
  output logic              busy_o,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        cyc_q;
  logic        stb_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [31:0] rdata_q;
  logic        err_q;

  // Byte offset bits are dropped: the bus is word addressed.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^bus.req_addr_i[1:0];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            state <= BUS;
            cnt   <= 8'd0;
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            we_q  <= bus.req_we_i;
            sel_q <= bus.req_sel_i;
            adr_q <= {bus.req_addr_i[31:2], 2'b00};
            dat_q <= bus.req_wdata_i;
          end
        end
        BUS: begin
          // An ack in the last allowed cycle still wins over the timeout.
          if (bus.wbm_ack_i) begin
            state   <= RESP;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            rdata_q <= we_q ? 32'd0 : bus.wbm_dat_i;
            err_q   <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state   <= RESP;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cyc_q <= 1'b0;
          stb_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_o = (state == IDLE);
  assign bus.rsp_valid_o = (state == RESP);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;
  assign bus.wbm_cyc_o   = cyc_q;
  assign bus.wbm_stb_o   = stb_q;
  assign bus.wbm_we_o    = we_q;
  assign bus.wbm_sel_o   = sel_q;
  assign bus.wbm_adr_o   = adr_q;
  assign bus.wbm_dat_o   = dat_q;
  assign busy_o          = (state != IDLE);
  assign dbg_state_o     = state;

endmodule

// File: tb/tb_wb_master.sv
// Bench for wb_master: directed corner cases plus random transactions against a transaction-level model.
module tb_wb_master;
  localparam int TIMEOUT = 16;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [1:0] dbg_state;
  int         errors = 0;
  int         checks = 0;
  logic [32:0] exp_q[$];
  logic [31:0] last_adr = 32'd0;
  logic [32:0] last_rsp = 33'd0;

  wb_master_if bus ();

  wb_master #(.TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .bus         (bus.master),
    .busy_o      (busy),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cyc"},   bus.wbm_cyc_o,   0);
    chk({tag, "_stb"},   bus.wbm_stb_o,   0);
    chk({tag, "_we"},    bus.wbm_we_o,    0);
    chk({tag, "_sel"},   bus.wbm_sel_o,   0);
    chk({tag, "_adr"},   bus.wbm_adr_o,   0);
    chk({tag, "_dat"},   bus.wbm_dat_o,   0);
    chk({tag, "_rspv"},  bus.rsp_valid_o, 0);
    chk({tag, "_rdata"}, bus.rsp_rdata_o, 0);
    chk({tag, "_err"},   bus.rsp_err_o,   0);
    chk({tag, "_busy"},  busy,            0);
    chk({tag, "_rdy"},   bus.req_ready_o, 1);
  endtask

  // Driver: one full transaction. ack_at is the BUS cycle (1-based) in which the slave acks; 0 means never.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input int ack_at, input logic [31:0] sdata,
                         input int bp);
    int n;
    int exp_stb;
    logic [32:0] exp_rsp;
    logic [32:0] got;
    logic [31:0] exp_adr;
    // Reference model: ack inside the window -> normal response, otherwise a timeout error.
    if (ack_at >= 1 && ack_at <= TIMEOUT) begin
      exp_stb = ack_at;
      exp_rsp = {1'b0, (we ? 32'd0 : sdata)};
    end else begin
      exp_stb = TIMEOUT;
      exp_rsp = {1'b1, 32'd0};
    end
    exp_q.push_back(exp_rsp);
    exp_adr = {addr[31:2], 2'b00};

    @(negedge clk);
    bus.rsp_ready_i = (bp == 0);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_sel_i   = sel;
    chk("req_ready_idle", bus.req_ready_o, 1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'($urandom);
    bus.req_addr_i  = $urandom;
    bus.req_wdata_i = $urandom;
    bus.req_sel_i   = 4'($urandom);
    chk("bus_cyc", bus.wbm_cyc_o, 1);
    chk("bus_we",  bus.wbm_we_o,  we);
    chk("bus_sel", bus.wbm_sel_o, sel);
    chk("bus_dat", bus.wbm_dat_o, wdata);
    chk("bus_rdy", bus.req_ready_o, 0);

    n = 0;
    while (bus.wbm_stb_o === 1'b1 && n < 300) begin
      n++;
      chk("bus_adr", bus.wbm_adr_o, exp_adr);
      bus.wbm_ack_i = (n == ack_at);
      bus.wbm_dat_i = (n == ack_at) ? sdata : $urandom;
      @(posedge clk); #1;
      bus.wbm_ack_i = 1'b0;
    end
    chk("stb_cycles", n, exp_stb);
    chk("cyc_low", bus.wbm_cyc_o, 0);

    // Scoreboard: response against the oldest expected entry.
    got = exp_q.pop_front();
    chk("rsp_valid", bus.rsp_valid_o, 1);
    chk("rsp_rdata", bus.rsp_rdata_o, got[31:0]);
    chk("rsp_err",   bus.rsp_err_o,   got[32]);

    if (bp > 0) begin
      bus.req_valid_i = 1'b1;
      for (int i = 0; i < bp; i++) begin
        bus.wbm_ack_i = 1'($urandom);
        bus.wbm_dat_i = $urandom;
        @(posedge clk); #1;
        chk("bp_valid", bus.rsp_valid_o, 1);
        chk("bp_rdata", bus.rsp_rdata_o, got[31:0]);
        chk("bp_err",   bus.rsp_err_o,   got[32]);
        chk("bp_rdy",   bus.req_ready_o, 0);
        chk("bp_stb",   bus.wbm_stb_o,   0);
      end
      bus.wbm_ack_i   = 1'b0;
      bus.rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_stb", bus.wbm_stb_o, 0);
      bus.req_valid_i = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    chk("rsp_done", bus.rsp_valid_o, 0);
    chk("idle_rdy", bus.req_ready_o, 1);
    last_adr = exp_adr;
    last_rsp = got;
  endtask

  task automatic stray_ack_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = $urandom;
      @(posedge clk); #1;
      chk("stray_busy",  busy,            0);
      chk("stray_cyc",   bus.wbm_cyc_o,   0);
      chk("stray_rspv",  bus.rsp_valid_o, 0);
      chk("stray_adr",   bus.wbm_adr_o,   last_adr);
      chk("stray_rdata", bus.rsp_rdata_o, last_rsp[31:0]);
      chk("stray_err",   bus.rsp_err_o,   last_rsp[32]);
    end
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
  endtask

  task automatic reset_mid_bus();
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 32'h4000_0010;
    bus.req_sel_i   = 4'hF;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_stb", bus.wbm_stb_o, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    last_adr = 32'd0;
    last_rsp = 33'd0;
    @(posedge clk); #1;
    chk("rst_after_stb", bus.wbm_stb_o, 0);
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 32'd0;
    bus.req_wdata_i = 32'd0;
    bus.req_sel_i   = 4'd0;
    bus.rsp_ready_i = 1'b1;
    bus.wbm_dat_i   = 32'd0;
    bus.wbm_ack_i   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(1'b0, 32'h3001_0007, 32'h0, 4'hF, 3, 32'hDEAD_BEEF, 0);
    run_txn(1'b1, 32'h3002_0008, 32'h1234_5678, 4'h3, 1, 32'hFFFF_FFFF, 0);
    run_txn(1'b0, 32'h3003_0000, 32'h0, 4'hF, 0, 32'h0, 0);
    run_txn(1'b0, 32'h3003_0004, 32'h0, 4'hF, TIMEOUT, 32'hCAFE_F00D, 0);
    run_txn(1'b0, 32'h3004_0002, 32'h0, 4'h1, 2, 32'hA5A5_5A5A, 5);
    stray_ack_idle(3);
    reset_mid_bus();
    run_txn(1'b0, 32'h3005_000C, 32'h0, 4'hF, 2, 32'h0BAD_CAFE, 0);

    for (int t = 0; t < 25; t++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
              $urandom_range(0, TIMEOUT + 4), $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) stray_ack_idle(1);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
